// File: rtl/udp_pkt_rx.sv
// UDP frame receiver: strips preamble and Ethernet/IPv4/UDP headers, filters on MAC/IP/port,
// streams the payload and reports FCS and length status at end of frame.
module udp_pkt_rx #(
    parameter logic [47:0] MY_MAC       = 48'hAADEADBEEFAA,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter logic [31:0] MY_IP        = 32'hC0A80164,
    parameter logic [15:0] MY_PORT      = 16'd1024,
    parameter logic [15:0] MAX_PAYLOAD  = 16'd1472
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        err_crc,
    output logic        err_len,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, TRAILER, STATUS, DROP} state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [10:0] IDX_MAX     = 11'h7FF;

    state_t      state, state_nx;
    logic [10:0] idx;
    logic [31:0] crc;
    logic        uc_ok, bc_ok;
    logic [31:0] ip_sh;
    logic [15:0] port_sh;
    logic [15:0] udp_len;

    logic [7:0]  mac_byte;
    logic        uc_m, bc_m;
    logic        chk_en;
    logic [7:0]  chk_val;
    logic        hdr_bad, len_bad;
    logic [15:0] plen;
    logic [10:0] last_idx;
    logic        pay_byte, drop_inc, go_status, crc_bad, stat_len, sfd_hit, frame_byte;

    // Serial-equivalent of the parallel nextCRC32_D8: d[7] enters the register first.
    function automatic logic [31:0] next_crc32_d8(input logic [7:0] d, input logic [31:0] c);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    // Header field checks, keyed on the byte index after the SFD.
    always_comb begin
        mac_byte = 8'h00;
        case (idx[2:0])
            3'd0:    mac_byte = MY_MAC[47:40];
            3'd1:    mac_byte = MY_MAC[39:32];
            3'd2:    mac_byte = MY_MAC[31:24];
            3'd3:    mac_byte = MY_MAC[23:16];
            3'd4:    mac_byte = MY_MAC[15:8];
            3'd5:    mac_byte = MY_MAC[7:0];
            default: mac_byte = 8'h00;
        endcase
        uc_m = uc_ok && (rx_data == mac_byte);
        bc_m = bc_ok && (rx_data == 8'hFF);

        chk_en  = 1'b0;
        chk_val = 8'h00;
        case (idx)
            11'd12: begin chk_en = 1'b1; chk_val = 8'h08;          end
            11'd13: begin chk_en = 1'b1; chk_val = 8'h00;          end
            11'd14: begin chk_en = 1'b1; chk_val = 8'h45;          end
            11'd23: begin chk_en = 1'b1; chk_val = 8'h11;          end
            11'd30: begin chk_en = 1'b1; chk_val = MY_IP[31:24];   end
            11'd31: begin chk_en = 1'b1; chk_val = MY_IP[23:16];   end
            11'd32: begin chk_en = 1'b1; chk_val = MY_IP[15:8];    end
            11'd33: begin chk_en = 1'b1; chk_val = MY_IP[7:0];     end
            11'd36: begin chk_en = 1'b1; chk_val = MY_PORT[15:8];  end
            11'd37: begin chk_en = 1'b1; chk_val = MY_PORT[7:0];   end
            default: begin chk_en = 1'b0; chk_val = 8'h00;         end
        endcase

        // Unicast and broadcast match are tracked separately so a mixed address never passes.
        hdr_bad  = (idx < 11'd6) ? !(uc_m || bc_m) : (chk_en && (rx_data != chk_val));
        plen     = udp_len - 16'd8;
        len_bad  = (udp_len < 16'd9) || (plen > MAX_PAYLOAD);
        last_idx = plen[10:0] + 11'd41;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:
                if (rx_dv && rx_data == 8'h55) state_nx = PREAMBLE;
            PREAMBLE:
                if (!rx_dv)                    state_nx = IDLE;
                else if (rx_data == 8'h55)     state_nx = PREAMBLE;
                else if (rx_data == 8'hD5)     state_nx = HEADER;
                else                           state_nx = DROP;
            HEADER:
                if (!rx_dv)                    state_nx = IDLE;
                else if (hdr_bad)              state_nx = DROP;
                else if (idx == 11'd41)        state_nx = len_bad ? DROP : PAYLOAD;
            PAYLOAD:
                if (!rx_dv)                    state_nx = STATUS;
                else if (idx == last_idx)      state_nx = TRAILER;
            TRAILER:
                if (!rx_dv)                    state_nx = STATUS;
            STATUS:                            state_nx = IDLE;
            DROP:
                if (!rx_dv)                    state_nx = IDLE;
            default:                           state_nx = IDLE;
        endcase
    end

    always_comb begin
        sfd_hit    = (state == PREAMBLE) && rx_dv && (rx_data == 8'hD5);
        frame_byte = rx_dv && (state == HEADER || state == PAYLOAD || state == TRAILER);
        pay_byte   = rx_dv && (state == PAYLOAD);
        go_status  = !rx_dv && (state == PAYLOAD || state == TRAILER);
        stat_len   = (state == PAYLOAD);
        crc_bad    = (crc != CRC_RESIDUE);
        // A header aborted by rx_dv low is still a filtered frame.
        drop_inc   = ((state_nx == DROP) && (state != DROP)) || ((state == HEADER) && !rx_dv);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_ok    <= 1'b0;
            err_crc   <= 1'b0;
            err_len   <= 1'b0;
            src_ip    <= 32'h0;
            src_port  <= 16'h0;
            drop_cnt  <= 16'h0;
            idx       <= 11'h0;
            crc       <= 32'hFFFFFFFF;
            uc_ok     <= 1'b0;
            bc_ok     <= 1'b0;
            ip_sh     <= 32'h0;
            port_sh   <= 16'h0;
            udp_len   <= 16'h0;
        end else begin
            out_valid <= pay_byte;
            out_sof   <= pay_byte && (idx == 11'd42);
            out_eof   <= pay_byte && (idx == last_idx);
            if (pay_byte) out_data <= rx_data;

            pkt_done <= go_status;
            pkt_ok   <= go_status && !crc_bad && !stat_len;
            err_crc  <= go_status && crc_bad;
            err_len  <= go_status && stat_len;
            if (go_status && !crc_bad && !stat_len) begin
                src_ip   <= ip_sh;
                src_port <= port_sh;
            end

            if (drop_inc) drop_cnt <= drop_cnt + 16'd1;

            if (sfd_hit) begin
                idx   <= 11'h0;
                crc   <= 32'hFFFFFFFF;
                uc_ok <= 1'b1;
                bc_ok <= ACCEPT_BCAST;
            end else if (frame_byte) begin
                crc <= next_crc32_d8(rev8(rx_data), crc);
                if (idx != IDX_MAX) idx <= idx + 11'd1;
            end

            if (state == HEADER && rx_dv) begin
                if (idx < 11'd6) begin
                    uc_ok <= uc_m;
                    bc_ok <= bc_m;
                end
                case (idx)
                    11'd26, 11'd27, 11'd28, 11'd29: ip_sh   <= {ip_sh[23:0], rx_data};
                    11'd34, 11'd35:                 port_sh <= {port_sh[7:0], rx_data};
                    11'd38, 11'd39:                 udp_len <= {udp_len[7:0], rx_data};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_pkt_rx.sv
// Bench for udp_pkt_rx: builds whole frames byte-by-byte, predicts the outcome from the
// frame contents (field checks, reflected CRC-32 residue) and compares stream and status.
module tb_udp_pkt_rx;

    localparam logic [47:0] MY_MAC  = 48'hAADEADBEEFAA;
    localparam logic [31:0] MY_IP   = 32'hC0A80164;
    localparam logic [15:0] MY_PORT = 16'd1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        out_valid, out_sof, out_eof, pkt_done, pkt_ok, err_crc, err_len;
    logic [7:0]  out_data;
    logic [31:0] src_ip;
    logic [15:0] src_port, drop_cnt;

    udp_pkt_rx dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_data(rx_data),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .err_crc(err_crc), .err_len(err_len),
        .src_ip(src_ip), .src_port(src_port), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  frm[$];
    logic [7:0]  pay[$];
    logic [9:0]  got_q[$];
    logic [9:0]  exp_q[$];
    int          got_done;
    logic        got_ok, got_ecrc, got_elen;
    logic        exp_done, exp_ok, exp_ecrc, exp_elen;
    logic [15:0] exp_drop = 16'h0;
    logic [31:0] exp_sip = 32'h0;
    logic [15:0] exp_sport = 16'h0;

    always @(negedge clk) begin
        if (out_valid) got_q.push_back({out_sof, out_eof, out_data});
        if (pkt_done) begin
            got_done = got_done + 1;
            got_ok   = pkt_ok;
            got_ecrc = err_crc;
            got_elen = err_len;
        end
    end

    // Reflected CRC-32 register value (no final inversion).
    function automatic logic [31:0] crc_refl(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_frame(input logic [47:0] dmac, input logic [31:0] sip,
                               input logic [15:0] sport, input logic [31:0] dip,
                               input logic [15:0] dport, input logic [15:0] ulen);
        logic [7:0]  b[$];
        logic [31:0] c;
        logic [15:0] tl;
        tl = ulen + 16'd20;
        for (int i = 0; i < 6; i++) b.push_back(dmac[47-8*i -: 8]);
        b.push_back(8'h02); b.push_back(8'h11); b.push_back(8'h22);
        b.push_back(8'h33); b.push_back(8'h44); b.push_back(8'h55);
        b.push_back(8'h08); b.push_back(8'h00); b.push_back(8'h45); b.push_back(8'h00);
        b.push_back(tl[15:8]); b.push_back(tl[7:0]);
        b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h40); b.push_back(8'h00);
        b.push_back(8'h40); b.push_back(8'h11); b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 0; i < 4; i++) b.push_back(sip[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) b.push_back(dip[31-8*i -: 8]);
        b.push_back(sport[15:8]); b.push_back(sport[7:0]);
        b.push_back(dport[15:8]); b.push_back(dport[7:0]);
        b.push_back(ulen[15:8]);  b.push_back(ulen[7:0]);
        b.push_back(8'h00); b.push_back(8'h00);
        foreach (pay[i]) b.push_back(pay[i]);
        while (b.size() < 60) b.push_back(8'h00);
        c = ~crc_refl(b);
        b.push_back(c[7:0]); b.push_back(c[15:8]); b.push_back(c[23:16]); b.push_back(c[31:24]);
        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        foreach (b[i]) frm.push_back(b[i]);
    endtask

    // Predicts the receiver's view of the bytes in frm exactly as they will be sent.
    task automatic model_frame();
        int          p, n;
        logic [7:0]  h[$];
        logic        acc, uc, bc;
        logic [15:0] ulen, plen;
        exp_q.delete();
        exp_done = 0; exp_ok = 0; exp_ecrc = 0; exp_elen = 0;
        p = 0;
        while (p < frm.size() && frm[p] == 8'h55) p++;
        if (p >= frm.size()) return;
        if (frm[p] != 8'hD5) begin exp_drop++; return; end
        for (int i = p + 1; i < frm.size(); i++) h.push_back(frm[i]);
        n = h.size();
        acc = (n >= 42);
        plen = 16'h0;
        if (acc) begin
            uc = 1'b1; bc = 1'b1;
            for (int i = 0; i < 6; i++) begin
                uc &= (h[i] == MY_MAC[47-8*i -: 8]);
                bc &= (h[i] == 8'hFF);
            end
            acc = (uc || bc) && h[12] == 8'h08 && h[13] == 8'h00 && h[14] == 8'h45 &&
                  h[23] == 8'h11 && {h[30], h[31], h[32], h[33]} == MY_IP &&
                  {h[36], h[37]} == MY_PORT;
            ulen = {h[38], h[39]};
            plen = ulen - 16'd8;
            acc &= (ulen >= 16'd9) && (plen <= 16'd1472);
        end
        if (!acc) begin exp_drop++; return; end
        exp_done = 1;
        exp_elen = (n < 42 + int'(plen));
        for (int k = 0; k < int'(plen) && 42 + k < n; k++)
            exp_q.push_back({k == 0, k == int'(plen) - 1, h[42+k]});
        exp_ecrc = (crc_refl(h) != 32'hDEBB20E3);
        exp_ok   = !exp_ecrc && !exp_elen;
        if (exp_ok) begin
            exp_sip   = {h[26], h[27], h[28], h[29]};
            exp_sport = {h[34], h[35]};
        end
    endtask

    task automatic send_frm();
        foreach (frm[i]) begin
            @(posedge clk); #1;
            rx_dv = 1'b1; rx_data = frm[i];
        end
        @(posedge clk); #1;
        rx_dv = 1'b0; rx_data = 8'h00;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic apply_frame();
        got_q.delete();
        got_done = 0;
        model_frame();
        send_frm();
    endtask

    task automatic fill_pay(input int len, input bit ramp);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if ({out_valid, out_data, out_sof, out_eof, pkt_done, pkt_ok, err_crc, err_len, src_ip, src_port, drop_cnt} !== '0) begin n_err++; $display("FAIL reset_outputs got nonzero valid=%b done=%b drop=%h sip=%h", out_valid, pkt_done, drop_cnt, src_ip); end
    endtask

    task automatic test_good();
        logic [31:0] sip = $urandom();
        logic [15:0] sport = 16'($urandom_range(1, 65535));
        fill_pay(16, 1);
        build_frame(MY_MAC, sip, sport, MY_IP, MY_PORT, 16'd24);
        apply_frame();
        n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL good_count got %0d want 16", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL good_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (got_done !== 1 || got_ok !== 1'b1) begin n_err++; $display("FAIL good_status got done=%0d ok=%b want 1/1", got_done, got_ok); end
        n_vec++; if (src_ip !== sip || src_port !== sport) begin n_err++; $display("FAIL good_src got %h:%h want %h:%h", src_ip, src_port, sip, sport); end
    endtask

    task automatic test_crc_err();
        fill_pay(16, 1);
        build_frame(MY_MAC, $urandom(), 16'h4321, MY_IP, MY_PORT, 16'd24);
        frm[8+42+5] = frm[8+42+5] ^ 8'h01;
        apply_frame();
        n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL crc_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL crc_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (got_done !== 1 || got_ok !== 1'b0 || got_ecrc !== 1'b1 || got_elen !== 1'b0) begin n_err++; $display("FAIL crc_status got done=%0d ok=%b crc=%b len=%b want 1/0/1/0", got_done, got_ok, got_ecrc, got_elen); end
        n_vec++; if (src_ip !== exp_sip || src_port !== exp_sport) begin n_err++; $display("FAIL crc_src got %h:%h want %h:%h", src_ip, src_port, exp_sip, exp_sport); end
    endtask

    task automatic test_filter();
        fill_pay(16, 0);
        build_frame(MY_MAC, $urandom(), 16'd5000, MY_IP, 16'd1025, 16'd24);
        apply_frame();
        n_vec++; if (got_q.size() !== 0 || got_done !== 0) begin n_err++; $display("FAIL port_drop got bytes=%0d done=%0d want 0/0", got_q.size(), got_done); end
        n_vec++; if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL port_dropcnt got %0d want %0d", drop_cnt, exp_drop); end
        build_frame(48'h112233445566, $urandom(), 16'd5000, MY_IP, MY_PORT, 16'd24);
        apply_frame();
        n_vec++; if (got_q.size() !== 0 || got_done !== 0) begin n_err++; $display("FAIL mac_drop got bytes=%0d done=%0d want 0/0", got_q.size(), got_done); end
        n_vec++; if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL mac_dropcnt got %0d want %0d", drop_cnt, exp_drop); end
        build_frame(48'hFFFFFFFFFFFF, $urandom(), 16'd777, MY_IP, MY_PORT, 16'd24);
        apply_frame();
        n_vec++; if (got_q.size() !== 16 || got_done !== 1 || got_ok !== 1'b1) begin n_err++; $display("FAIL bcast got bytes=%0d done=%0d ok=%b want 16/1/1", got_q.size(), got_done, got_ok); end
        n_vec++; if (src_ip !== exp_sip || src_port !== exp_sport) begin n_err++; $display("FAIL bcast_src got %h:%h want %h:%h", src_ip, src_port, exp_sip, exp_sport); end
    endtask

    task automatic test_padding();
        fill_pay(4, 0);
        build_frame(MY_MAC, $urandom(), 16'd99, MY_IP, MY_PORT, 16'd12);
        apply_frame();
        n_vec++; if (got_q.size() !== 4) begin n_err++; $display("FAIL pad_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pad_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (got_done !== 1 || got_ok !== 1'b1) begin n_err++; $display("FAIL pad_status got done=%0d ok=%b want 1/1", got_done, got_ok); end
    endtask

    task automatic test_truncation();
        bit eof_seen = 0;
        fill_pay(16, 1);
        build_frame(MY_MAC, $urandom(), 16'd55, MY_IP, MY_PORT, 16'd24);
        while (frm.size() > 8 + 42 + 8) void'(frm.pop_back());
        apply_frame();
        foreach (got_q[i]) if (got_q[i][8]) eof_seen = 1;
        n_vec++; if (got_q.size() !== 8 || eof_seen) begin n_err++; $display("FAIL trunc_stream got bytes=%0d eof=%b want 8/0", got_q.size(), eof_seen); end
        n_vec++; if (got_done !== 1 || got_elen !== 1'b1 || got_ok !== 1'b0) begin n_err++; $display("FAIL trunc_status got done=%0d len=%b ok=%b want 1/1/0", got_done, got_elen, got_ok); end
    endtask

    task automatic test_reset_mid();
        fill_pay(16, 0);
        build_frame(MY_MAC, $urandom(), 16'd2222, MY_IP, MY_PORT, 16'd24);
        for (int i = 0; i < 8 + 42 + 6; i++) begin
            @(posedge clk); #1;
            rx_dv = 1'b1; rx_data = frm[i];
        end
        @(posedge clk); #1;
        rst_n = 1'b0; rx_data = frm[8+42+6];
        @(posedge clk); #1;
        rst_n = 1'b1; rx_dv = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        n_vec++; if ({out_valid, out_data, out_sof, out_eof, pkt_done, pkt_ok, err_crc, err_len, src_ip, src_port, drop_cnt} !== '0) begin n_err++; $display("FAIL midrst_outputs got valid=%b done=%b drop=%h sip=%h", out_valid, pkt_done, drop_cnt, src_ip); end
        exp_drop = 16'h0; exp_sip = 32'h0; exp_sport = 16'h0;
        repeat (4) @(posedge clk);
        got_q.delete(); got_done = 0;
        fill_pay(16, 0);
        build_frame(MY_MAC, $urandom(), 16'd3333, MY_IP, MY_PORT, 16'd24);
        apply_frame();
        n_vec++; if (got_done !== 1 || got_ok !== 1'b1 || got_q.size() !== 16) begin n_err++; $display("FAIL midrst_next got done=%0d ok=%b bytes=%0d want 1/1/16", got_done, got_ok, got_q.size()); end
        n_vec++; if (drop_cnt !== 16'd0 || src_port !== 16'd3333) begin n_err++; $display("FAIL midrst_regs got drop=%0d sport=%0d want 0/3333", drop_cnt, src_port); end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            fill_pay(20 + f * 7, 0);
            build_frame(MY_MAC, $urandom(), 16'($urandom_range(1, 65535)), MY_IP, MY_PORT, 16'(28 + f * 7));
            apply_frame();
            n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b%0d_count got %0d want %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b%0d_byte%0d got %h want %h", f, i, got_q[i], exp_q[i]); end
            end
            n_vec++; if (got_done !== 1 || got_ok !== 1'b1) begin n_err++; $display("FAIL b2b%0d_status got done=%0d ok=%b want 1/1", f, got_done, got_ok); end
            n_vec++; if (src_ip !== exp_sip || src_port !== exp_sport) begin n_err++; $display("FAIL b2b%0d_src got %h:%h want %h:%h", f, src_ip, src_port, exp_sip, exp_sport); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            int          r = $urandom_range(0, 9);
            int          plen = $urandom_range(1, 40);
            logic [47:0] dmac = MY_MAC;
            logic [15:0] dport = MY_PORT;
            logic [15:0] ulen = 16'(plen + 8);
            logic [31:0] dip = MY_IP;
            if (r == 0) dmac = {16'h1234, $urandom()};
            if (r == 1) dmac = 48'hFFFFFFFFFFFF;
            if (r == 2) dport = MY_PORT + 16'd1;
            if (r == 3) ulen = 16'd8;
            if (r == 4) ulen = 16'd1490;
            if (r == 7) dip = MY_IP ^ 32'h00000100;
            fill_pay(plen, 0);
            build_frame(dmac, $urandom(), 16'($urandom_range(1, 65535)), dip, dport, ulen);
            if (r == 5) begin
                int c = 8 + 42 + $urandom_range(0, plen - 1);
                frm[c] = frm[c] ^ 8'h01;
            end
            if (r == 6) begin
                int keep = $urandom_range(8 + 30, frm.size() - 1);
                while (frm.size() > keep) void'(frm.pop_back());
            end
            apply_frame();
            n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rnd%0d_count got %0d want %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_byte%0d got %h want %h", f, i, got_q[i], exp_q[i]); end
            end
            n_vec++; if (got_done !== int'(exp_done)) begin n_err++; $display("FAIL rnd%0d_done got %0d want %0d", f, got_done, exp_done); end
            if (exp_done) begin
                n_vec++; if ({got_ok, got_ecrc, got_elen} !== {exp_ok, exp_ecrc, exp_elen}) begin n_err++; $display("FAIL rnd%0d_status got ok/crc/len=%b%b%b want %b%b%b", f, got_ok, got_ecrc, got_elen, exp_ok, exp_ecrc, exp_elen); end
            end
            n_vec++; if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL rnd%0d_dropcnt got %0d want %0d", f, drop_cnt, exp_drop); end
            n_vec++; if (src_ip !== exp_sip || src_port !== exp_sport) begin n_err++; $display("FAIL rnd%0d_src got %h:%h want %h:%h", f, src_ip, src_port, exp_sip, exp_sport); end
        end
    endtask

    initial begin
        got_done = 0;
        test_reset();
        test_good();
        test_crc_err();
        test_filter();
        test_padding();
        test_truncation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
